// File: rtl/mul_arbiter_if.sv
// Requester job/response handshake and multiplier-component bus for mul_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mul_arbiter_if;
    logic [1:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        busy;
    logic [1:0]  mul_address;
    logic [31:0] mul_writedata;
    logic        mul_write;
    logic        mul_read;
    logic        mul_chipselect;
    logic [31:0] mul_readdata;

    modport slave (
        input  req_valid, req_a, req_b, mul_readdata,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy,
               mul_address, mul_writedata, mul_write, mul_read, mul_chipselect
    );

    modport master (
        output req_valid, req_a, req_b, mul_readdata,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy,
               mul_address, mul_writedata, mul_write, mul_read, mul_chipselect
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one Avalon-style multiplier between two requesters;
// one job in flight: write A, write B, settle RESULT_LAT cycles, read, respond.
module mul_arbiter #(
    parameter int unsigned RESULT_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    mul_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WR_A, WR_B, WAIT, RD, RESP} state_t;

    // Only loaded on the way into WAIT, so the zero-latency case never uses it.
    localparam logic [3:0] LAT_M1 = (RESULT_LAT > 0) ? 4'(RESULT_LAT - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        id_q, id_d;
    logic        last_q, last_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_id_q, rsp_id_d;
    logic        grant;

    // Tie goes to the requester that did not win last time.
    always_comb begin
        grant = (bus.req_valid == 2'b11) ? ~last_q : bus.req_valid[1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            id_q       <= 1'b0;
            last_q     <= 1'b1;
            rsp_data_q <= 32'd0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            id_q       <= id_d;
            last_q     <= last_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        a_d                = a_q;
        b_d                = b_q;
        id_d               = id_q;
        last_d             = last_q;
        rsp_data_d         = rsp_data_q;
        rsp_id_d           = rsp_id_q;
        bus.mul_address    = 2'd0;
        bus.mul_writedata  = 32'd0;
        bus.mul_write      = 1'b0;
        bus.mul_read       = 1'b0;
        bus.mul_chipselect = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    a_d     = grant ? bus.req_a[63:32] : bus.req_a[31:0];
                    b_d     = grant ? bus.req_b[63:32] : bus.req_b[31:0];
                    id_d    = grant;
                    last_d  = grant;
                    state_d = WR_A;
                end
            end
            WR_A: begin
                bus.mul_address    = 2'd0;
                bus.mul_writedata  = a_q;
                bus.mul_write      = 1'b1;
                bus.mul_chipselect = 1'b1;
                state_d            = WR_B;
            end
            WR_B: begin
                bus.mul_address    = 2'd1;
                bus.mul_writedata  = b_q;
                bus.mul_write      = 1'b1;
                bus.mul_chipselect = 1'b1;
                if (RESULT_LAT > 0) begin
                    cnt_d   = LAT_M1;
                    state_d = WAIT;
                end else begin
                    state_d = RD;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RD: begin
                bus.mul_address    = 2'd2;
                bus.mul_read       = 1'b1;
                bus.mul_chipselect = 1'b1;
                rsp_data_d         = bus.mul_readdata;
                rsp_id_d           = id_q;
                state_d            = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 2'b00;
        if (state_q == IDLE && !reset && |bus.req_valid)
            bus.req_ready = grant ? 2'b10 : 2'b01;
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: RESULT_LAT=1 and RESULT_LAT=0 instances,
// each backed by a small behavioural model of the multiplier component.
module tb_mul_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mul_arbiter_if if1 ();
    mul_arbiter_if if0 ();

    mul_arbiter #(.RESULT_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    mul_arbiter #(.RESULT_LAT(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));

    // Multiplier component models: operand registers, combinational low-32 product.
    logic [31:0] ma1, mb1, ma0, mb0;
    always @(posedge clk) begin
        if (if1.mul_chipselect && if1.mul_write) begin
            if (if1.mul_address == 2'd0) ma1 <= if1.mul_writedata;
            if (if1.mul_address == 2'd1) mb1 <= if1.mul_writedata;
        end
        if (if0.mul_chipselect && if0.mul_write) begin
            if (if0.mul_address == 2'd0) ma0 <= if0.mul_writedata;
            if (if0.mul_address == 2'd1) mb0 <= if0.mul_writedata;
        end
    end
    assign if1.mul_readdata = ma1 * mb1;
    assign if0.mul_readdata = ma0 * mb0;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Compares address, writedata (optional), write, read, chipselect of dut1.
    task automatic bus_chk(input string nm, input logic [1:0] ad, input logic [31:0] wd,
                           input logic wr, input logic rd, input logic cs, input logic use_wd);
        logic [31:0] wd_exp;
        wd_exp = use_wd ? wd : if1.mul_writedata;
        chk(nm, {if1.mul_address, if1.mul_writedata, if1.mul_write, if1.mul_read, if1.mul_chipselect},
                {ad, wd_exp, wr, rd, cs});
    endtask

    task automatic run_job(input vec_t v);
        @(negedge clk);
        if1.req_valid = v.id ? 2'b10 : 2'b01;
        if (v.id) begin if1.req_a[63:32] = v.a; if1.req_b[63:32] = v.b; end
        else      begin if1.req_a[31:0]  = v.a; if1.req_b[31:0]  = v.b; end
        #1;
        chk("job_ready", if1.req_ready, v.id ? 2'b10 : 2'b01);
        chk("job_idle_busy", if1.busy, 0);
        @(negedge clk);
        if1.req_valid = 2'b00;
        bus_chk("job_wr_a", 2'd0, v.a, 1, 0, 1, 1);
        chk("job_busy", if1.busy, 1);
        @(negedge clk);
        bus_chk("job_wr_b", 2'd1, v.b, 1, 0, 1, 1);
        @(negedge clk);
        chk("job_wait", {if1.mul_write, if1.mul_read, if1.mul_chipselect}, 3'b000);
        @(negedge clk);
        bus_chk("job_rd", 2'd2, 32'd0, 0, 1, 1, 0);
        chk("job_no_early_rsp", if1.rsp_valid, 0);
        @(negedge clk);
        chk("job_rsp", {if1.rsp_valid, if1.rsp_id, if1.rsp_data}, {1'b1, v.id, v.exp});
        bus_chk("job_resp_bus", 2'd0, 32'd0, 0, 0, 0, 1);
        @(negedge clk);
        chk("job_done", {if1.rsp_valid, if1.busy}, 2'b00);
    endtask

    initial begin
        int nrsp, low;
        vecs[0] = '{1'b0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1] = '{1'b1, 32'h00010000,   32'h00010000, 32'h00000000};
        vecs[2] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000001};
        vecs[3] = '{1'b1, 32'h7FFFFFFF,   32'd2,        32'hFFFFFFFE};
        vecs[4] = '{1'b1, 32'hFFFFFFFB,   32'd6,        32'hFFFFFFE2};

        if1.req_valid = 2'b11;
        if1.req_a = {32'd4, 32'd2};
        if1.req_b = {32'd5, 32'd3};
        if0.req_valid = 2'b00;
        if0.req_a = 64'd0;
        if0.req_b = 64'd0;

        // Reset state, with both requests already pending.
        repeat (2) @(negedge clk);
        chk("rst_ready", if1.req_ready, 2'b00);
        chk("rst_outs", {if1.busy, if1.rsp_valid, if1.rsp_id, if1.rsp_data}, 35'd0);
        chk("rst_bus", {if1.mul_write, if1.mul_read, if1.mul_chipselect}, 3'b000);
        reset = 1'b0;
        #1;
        chk("first_tie_ready", if1.req_ready, 2'b01);

        // Contention from reset: 0,1,0,1 with one idle cycle between jobs.
        nrsp = 0;
        low = 0;
        for (int cyc = 0; cyc < 60 && nrsp < 4; cyc++) begin
            @(negedge clk);
            chk("ready_onehot", if1.req_ready == 2'b11, 0);
            if (if1.rsp_valid) begin
                chk("cont_rsp_id", if1.rsp_id, nrsp % 2);
                chk("cont_rsp_data", if1.rsp_data, (nrsp % 2) ? 32'd20 : 32'd6);
                nrsp++;
            end
            if (!if1.busy) low++;
            else if (low > 0) begin
                if (nrsp > 0) chk("cont_gap", low, 1);
                low = 0;
            end
        end
        chk("cont_count", nrsp, 4);
        if1.req_valid = 2'b00;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) run_job(vecs[i]);

        // Reset during WAIT after a requester-0 job: job dropped, tie then goes to 0.
        @(negedge clk);
        if1.req_valid = 2'b01;
        if1.req_a[31:0] = 32'd9;
        if1.req_b[31:0] = 32'd9;
        @(negedge clk);
        if1.req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("mid_in_wait", {if1.busy, if1.mul_chipselect}, 2'b10);
        reset = 1'b1;
        #1;
        chk("mid_rst_outs", {if1.busy, if1.rsp_valid, if1.rsp_id, if1.rsp_data, if1.req_ready}, 37'd0);
        chk("mid_rst_bus", {if1.mul_address, if1.mul_writedata, if1.mul_write, if1.mul_read,
                            if1.mul_chipselect}, 37'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mid_no_rsp", if1.rsp_valid, 0);
        end
        if1.req_valid = 2'b11;
        if1.req_a = {32'd4, 32'd2};
        if1.req_b = {32'd5, 32'd3};
        reset = 1'b0;
        #1;
        chk("post_rst_tie", if1.req_ready, 2'b01);
        @(negedge clk);
        if1.req_valid = 2'b00;
        repeat (3) @(negedge clk);
        chk("post_rst_no_rsp", if1.rsp_valid, 0);
        @(negedge clk);
        chk("post_rst_rsp", {if1.rsp_valid, if1.rsp_id, if1.rsp_data}, {1'b1, 1'b0, 32'd6});

        // RESULT_LAT=0: read directly after WR_B, response at T+4.
        @(negedge clk);
        if0.req_valid = 2'b01;
        if0.req_a[31:0] = 32'd3;
        if0.req_b[31:0] = 32'hFFFFFFFC;
        #1;
        chk("lat0_ready", if0.req_ready, 2'b01);
        @(negedge clk);
        if0.req_valid = 2'b00;
        chk("lat0_wr_a", {if0.mul_address, if0.mul_writedata, if0.mul_write, if0.mul_read,
                          if0.mul_chipselect}, {2'd0, 32'd3, 3'b101});
        @(negedge clk);
        chk("lat0_wr_b", {if0.mul_address, if0.mul_writedata, if0.mul_write, if0.mul_read,
                          if0.mul_chipselect}, {2'd1, 32'hFFFFFFFC, 3'b101});
        @(negedge clk);
        chk("lat0_rd", {if0.mul_address, if0.mul_write, if0.mul_read, if0.mul_chipselect},
                       {2'd2, 3'b011});
        @(negedge clk);
        chk("lat0_rsp", {if0.rsp_valid, if0.rsp_id, if0.rsp_data}, {1'b1, 1'b0, 32'hFFFFFFF4});
        @(negedge clk);
        chk("lat0_done", {if0.rsp_valid, if0.busy}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
